rr_packet_arbiter: RTL and testbench

//  Round-robin, packet-locking arbiter sharing one output port/link among N_REQ

---
 rtl/rr_packet_arbiter.sv | 151 +++++++++++++++
 tb/tb_rr_packet_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter
//   Round-robin arbiter that shares one output link among N_REQ requesters
//   and locks the grant for a whole packet. The grant is held until the
//   granted requester's tail flit is transferred. Priority then rotates to
//   the requester just after the one that finished.
//
// Ports
//   clk          rising-edge clock
//   reset_n      synchronous, active-low reset
//   i_req        per-requester flit valid
//   i_tail       per-requester "offered flit is the packet tail"
//   i_ready      downstream accepts a flit this cycle
//   o_gnt        registered one-hot grant, all-zero when idle
//   o_gnt_idx    registered binary index of the o_gnt bit, 0 when idle
//   o_gnt_valid  registered, high whenever o_gnt is non-zero
//   o_xfer       a flit of the granted requester moves this cycle
//   o_pop        one-hot dequeue strobe for the granted requester

module rr_packet_arbiter #(
  parameter int N_REQ     = 8,
  parameter int IDX_WIDTH = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ-1:0]     i_tail,
  input  logic                 i_ready,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [IDX_WIDTH-1:0] o_gnt_idx,
  output logic                 o_gnt_valid,
  output logic                 o_xfer,
  output logic [N_REQ-1:0]     o_pop
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_REQ - 1);

  state_t               state;
  state_t               next_state;
  logic [IDX_WIDTH-1:0] ptr;
  logic [IDX_WIDTH-1:0] next_ptr;
  logic [N_REQ-1:0]     next_gnt;
  logic [IDX_WIDTH-1:0] next_idx;

  logic [IDX_WIDTH-1:0] rel_base;
  logic [IDX_WIDTH-1:0] pick_base;
  logic [N_REQ-1:0]     pick_mask;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 win_found;
  logic                 release_now;

  // Position base+offset in the rotated search order, wrapping at N_REQ.
  // Handles N_REQ values that are not a power of two.
  function automatic logic [IDX_WIDTH-1:0] rot(input logic [IDX_WIDTH-1:0] base,
                                               input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return IDX_WIDTH'(sum);
  endfunction

  // State register. Grant and pointer are registered, so they only move on
  // a clock edge. Reset also drops any packet lock in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      o_gnt     <= '0;
      o_gnt_idx <= '0;
    end else begin
      state     <= next_state;
      ptr       <= next_ptr;
      o_gnt     <= next_gnt;
      o_gnt_idx <= next_idx;
    end
  end

  // Output decode. o_gnt_valid comes straight from the state flop, because
  // LOCKED holds exactly when o_gnt is non-zero.
  always_comb begin
    o_gnt_valid = (state == LOCKED);
    o_xfer      = o_gnt_valid & i_req[o_gnt_idx] & i_ready;
    o_pop       = o_gnt & {N_REQ{o_xfer}};
  end

  // Release happens on the tail flit of the current owner. Tail bits from
  // other requesters never reach this point.
  assign release_now = o_xfer & i_tail[o_gnt_idx];
  assign rel_base    = (o_gnt_idx == LAST_IDX) ? '0 : o_gnt_idx + IDX_WIDTH'(1);

  // When idle, search all requests starting at ptr. On release, exclude the
  // finishing requester and start just after it. The new ptr takes effect in
  // the same cycle, which gives zero-bubble hand-over.
  assign pick_mask = (state == IDLE) ? i_req : (i_req & ~o_gnt);
  assign pick_base = (state == IDLE) ? ptr : rel_base;

  // Rotating priority search: the first set mask bit at or after pick_base wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && pick_mask[rot(pick_base, i)]) begin
        win_found = 1'b1;
        win_idx   = rot(pick_base, i);
      end
    end
  end

  // Next-state logic. A locked grant only changes on a release. The pointer
  // only advances on a release.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_gnt   = o_gnt;
    next_idx   = o_gnt_idx;
    case (state)
      IDLE: begin
        if (win_found) begin
          next_state        = LOCKED;
          next_gnt          = '0;
          next_gnt[win_idx] = 1'b1;
          next_idx          = win_idx;
        end
      end
      LOCKED: begin
        if (release_now) begin
          next_ptr = rel_base;
          if (win_found) begin
            next_gnt          = '0;
            next_gnt[win_idx] = 1'b1;
            next_idx          = win_idx;
          end else begin
            next_state = IDLE;
            next_gnt   = '0;
            next_idx   = '0;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_gnt   = '0;
        next_idx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// tb_rr_packet_arbiter
//   Self-checking bench for rr_packet_arbiter with N_REQ=4. A reference model
//   tracks the packet owner (or -1 when idle) and the rotating start point as
//   plain integers. Every cycle it predicts all outputs from the current inputs.
//   Directed scenarios come first, then a randomized run.

module tb_rr_packet_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] i_req;
  logic [N-1:0] i_tail;
  logic         i_ready;
  logic [N-1:0] o_gnt;
  logic [W-1:0] o_gnt_idx;
  logic         o_gnt_valid;
  logic         o_xfer;
  logic [N-1:0] o_pop;

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  rr_packet_arbiter #(.N_REQ(N), .IDX_WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (i_req),
    .i_tail     (i_tail),
    .i_ready    (i_ready),
    .o_gnt      (o_gnt),
    .o_gnt_idx  (o_gnt_idx),
    .o_gnt_valid(o_gnt_valid),
    .o_xfer     (o_xfer),
    .o_pop      (o_pop)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model state: current packet owner (-1 = idle) and where the next search starts.
  int m_owner = -1;
  int m_start = 0;

  logic [11:0] exp_vec;
  wire  [11:0] obs = {o_gnt, o_gnt_idx, o_gnt_valid, o_xfer, o_pop};

  // First requester with a set mask bit, scanning from 'start' and wrapping around.
  function automatic int m_pick(input logic [N-1:0] mask, input int start);
    int k;
    for (int i = 0; i < N; i++) begin
      k = (start + i) % N;
      if (mask[k]) return k;
    end
    return -1;
  endfunction

  // Drive inputs just after the falling edge, then predict all outputs for this cycle.
  task automatic apply(input logic [N-1:0] r, input logic [N-1:0] t,
                       input logic rdy, input logic rn);
    logic [N-1:0] eg;
    logic [W-1:0] ei;
    logic         ev;
    logic         ex;
    i_req   = r;
    i_tail  = t;
    i_ready = rdy;
    reset_n = rn;
    #1;
    eg = '0;
    ei = '0;
    ev = 1'b0;
    ex = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ei          = W'(m_owner);
      ev          = 1'b1;
      ex          = r[m_owner] & rdy;
    end
    exp_vec = {eg, ei, ev, ex, (ex ? eg : 4'b0000)};
  endtask

  // Advance the model by one clock edge, then move to the next falling edge.
  task automatic advance();
    if (!reset_n) begin
      m_owner = -1;
      m_start = 0;
    end else if (m_owner < 0) begin
      m_owner = m_pick(i_req, m_start);
    end else if (i_ready && i_req[m_owner] && i_tail[m_owner]) begin
      m_start = (m_owner + 1) % N;
      m_owner = m_pick(i_req & ~(N'(1) << m_owner), m_start);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      apply(4'($urandom), 4'($urandom), 1'b1, 1'b0);
      vectors++;
      if (obs !== 12'h000) begin
        miscompares++;
        $display("[TB] FAIL test_reset c%0d: got %b want %b", c, obs, 12'h000);
      end
      advance();
    end
  endtask

  task automatic test_single();
    apply(4'b0100, 4'b0000, 1'b0, 1'b1);
    vectors++;
    if (obs !== exp_vec) begin
      miscompares++;
      $display("[TB] FAIL test_single idle: got %b want %b", obs, exp_vec);
    end
    advance();
    apply(4'b0100, 4'b0100, 1'b1, 1'b1);
    vectors++;
    if (o_gnt !== 4'b0100 || o_gnt_idx !== 2'd2 || o_xfer !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL test_single grant: got gnt=%b idx=%0d xfer=%b want 0100/2/1",
               o_gnt, o_gnt_idx, o_xfer);
    end
    advance();
    apply(4'b0000, 4'b0000, 1'b1, 1'b1);
    vectors++;
    if (o_gnt !== 4'b0000 || o_gnt_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL test_single release: got gnt=%b valid=%b want 0000/0",
               o_gnt, o_gnt_valid);
    end
    advance();
    // The search now starts at requester 3, so with every request raised,
    // requester 3 is the winner.
    apply(4'b1111, 4'b0000, 1'b0, 1'b1);
    advance();
    apply(4'b1111, 4'b0000, 1'b0, 1'b1);
    vectors++;
    if (o_gnt_idx !== 2'd3 || obs !== exp_vec) begin
      miscompares++;
      $display("[TB] FAIL test_single ptr: got %b want %b", obs, exp_vec);
    end
    advance();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply(4'b0000, 4'b0000, 1'b0, 1'b0);
    advance();
    apply(4'b1111, 4'b1111, 1'b1, 1'b1);
    advance();
    for (int c = 0; c < 5; c++) begin
      apply(4'b1111, 4'b1111, 1'b1, 1'b1);
      vectors++;
      if (o_gnt !== seq[c] || obs !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL test_round_robin c%0d: got gnt=%b (%b) want gnt=%b (%b)",
                 c, o_gnt, obs, seq[c], exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_hold();
    // Each step is {req, tail, ready}.
    logic [8:0] steps [7] = '{
      {4'b0010, 4'b0000, 1'b0},
      {4'b0011, 4'b0000, 1'b1},
      {4'b0011, 4'b0000, 1'b0},
      {4'b0011, 4'b0010, 1'b0},
      {4'b0011, 4'b0000, 1'b1},
      {4'b0011, 4'b0010, 1'b1},
      {4'b0001, 4'b0000, 1'b0}
    };
    apply(4'b0000, 4'b0000, 1'b0, 1'b0);
    advance();
    for (int c = 0; c < 7; c++) begin
      apply(steps[c][8:5], steps[c][4:1], steps[c][0], 1'b1);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL test_hold c%0d: got %b want %b", c, obs, exp_vec);
      end
      advance();
    end
    apply(4'b1001, 4'b0000, 1'b0, 1'b1);
    vectors++;
    if (o_gnt !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL test_hold after_tail: got gnt=%b want 0001", o_gnt);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 7; c++) begin
      apply(4'b0100, 4'b0100, 1'b1, 1'b1);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL test_back_to_back c%0d: got %b want %b", c, obs, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    apply(4'b0010, 4'b0000, 1'b1, 1'b1);
    advance();
    apply(4'b1111, 4'b0000, 1'b1, 1'b0);
    advance();
    apply(4'b1111, 4'b0000, 1'b1, 1'b1);
    vectors++;
    if (o_gnt !== 4'b0000 || o_gnt_valid !== 1'b0 || obs !== exp_vec) begin
      miscompares++;
      $display("[TB] FAIL test_reset_mid cleared: got %b want %b", obs, exp_vec);
    end
    advance();
    apply(4'b1111, 4'b0000, 1'b0, 1'b1);
    vectors++;
    if (o_gnt_idx !== 2'd0 || o_gnt !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL test_reset_mid regrant: got idx=%0d gnt=%b want 0/0001",
               o_gnt_idx, o_gnt);
    end
    advance();
  endtask

  task automatic test_gap();
    apply(4'b0000, 4'b0000, 1'b0, 1'b0);
    advance();
    apply(4'b0100, 4'b0000, 1'b1, 1'b1);
    advance();
    for (int c = 0; c < 3; c++) begin
      apply(4'b1011, 4'b1111, 1'b1, 1'b1);
      vectors++;
      if (o_gnt !== 4'b0100 || o_xfer !== 1'b0 || obs !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL test_gap c%0d: got %b want %b", c, obs, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic rdy;
    logic rn;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rn  = ($urandom_range(0, 59) != 0);
      apply(4'($urandom), 4'($urandom), rdy, rn);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("[TB] FAIL test_random c%0d: got %b want %b", c, obs, exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    i_req   = '0;
    i_tail  = '0;
    i_ready = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_gap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
